// File: rtl/piho_result_sink_if.sv
// Byte stream from the result sink toward the UART/host bridge.
//   out_data  : frame byte
//   out_valid : out_data is valid
//   out_ready : consumer accepts the byte when out_valid is also high
// master = producer (result sink), slave = consumer.
interface piho_result_sink_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/piho_result_sink.sv
// Result sink for the path-integral harmonic-oscillator array.
// On the rising edge of finish, it first waits SETTLE cycles for the x2sum adder tree.
// It then captures x2sumall and looptimes, and divides x2sumall by (MCNconf - MCNdump)
// with a serial restoring divider. Finally it streams a 23-byte checksummed frame.
//   clk, rst    : clock, synchronous active-high reset
//   finish      : run-complete level from the array
//   x2sumall    : 64-bit pipelined sum of squares
//   looptimes   : 32-bit loop counter
//   MCNconf     : total configurations
//   MCNdump     : discarded warm-up configurations
//   stream      : out_data / out_valid / out_ready byte stream (master side)
//   busy        : high in every state except IDLE
//   done        : one-cycle pulse after the last byte is accepted
module piho_result_sink #(
  parameter int unsigned SETTLE = 4,
  parameter logic [7:0]  HEADER = 8'hA5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       finish,
  input  logic [63:0]                x2sumall,
  input  logic [31:0]                looptimes,
  input  logic [31:0]                MCNconf,
  input  logic [31:0]                MCNdump,
  piho_result_sink_if.master         stream,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned NBYTES = 23;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned CNT_W  = 7;
  localparam int unsigned DIV_IT = 64;

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_DIVIDE, S_SEND, S_DONE} state_e;

  state_e             state_q, state_d;
  logic               finish_d_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [63:0]        x2_q, x2_d;
  logic [31:0]        loop_q, loop_d;
  logic [31:0]        div_q, div_d;
  logic [63:0]        q_q, q_d;       // dividend shifts out MSB-first, quotient shifts in
  logic [32:0]        rem_q, rem_d;
  logic [7:0]         flags_q, flags_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         csum_q, csum_d;
  logic [7:0]         out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [33:0]        rem_sh, rem_diff;
  logic [IDX_W-1:0]   nxt_idx;
  logic [2:0]         sel_x2, sel_q;
  logic [1:0]         sel_lt;
  logic [7:0]         nxt_byte;

  // One restoring-division step: shift in the next dividend bit, try to subtract.
  always_comb begin
    rem_sh   = {rem_q, q_q[63]};
    rem_diff = rem_sh - {2'b00, div_q};
  end

  // Frame byte following the one currently presented (checksum byte handled in SEND).
  always_comb begin
    nxt_byte = '0;
    nxt_idx  = idx_q + IDX_W'(1);
    sel_x2   = 3'(nxt_idx - IDX_W'(2));
    sel_q    = 3'(nxt_idx - IDX_W'(10));
    sel_lt   = 2'(nxt_idx - IDX_W'(18));
    if (nxt_idx == IDX_W'(1))       nxt_byte = flags_q;
    else if (nxt_idx <= IDX_W'(9))  nxt_byte = x2_q[{sel_x2, 3'b000} +: 8];
    else if (nxt_idx <= IDX_W'(17)) nxt_byte = q_q[{sel_q, 3'b000} +: 8];
    else                            nxt_byte = loop_q[{sel_lt, 3'b000} +: 8];
  end

  // Next-state and datapath.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    x2_d       = x2_q;
    loop_d     = loop_q;
    div_d      = div_q;
    q_d        = q_q;
    rem_d      = rem_q;
    flags_d    = flags_q;
    idx_d      = idx_q;
    csum_d     = csum_q;
    out_data_d = out_data_q;

    case (state_q)
      S_IDLE: begin
        if (finish && !finish_d_q) begin
          state_d = S_SETTLE;
          cnt_d   = CNT_W'(SETTLE - 1);
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          x2_d    = x2sumall;
          loop_d  = looptimes;
          div_d   = MCNconf - MCNdump;
          q_d     = x2sumall;
          rem_d   = '0;
          flags_d = '0;
          state_d = S_DIVIDE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DIVIDE: begin
        // cnt_q is 0 on entry; one extra cycle after the last step aligns SEND entry.
        if (div_q == '0) begin
          flags_d = 8'h01;
          q_d     = '1;
          state_d = S_SEND;
        end else if (cnt_q == CNT_W'(DIV_IT)) begin
          state_d = S_SEND;
        end else begin
          if (!rem_diff[33]) begin
            rem_d = rem_diff[32:0];
            q_d   = {q_q[62:0], 1'b1};
          end else begin
            rem_d = rem_sh[32:0];
            q_d   = {q_q[62:0], 1'b0};
          end
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (state_d == S_SEND) begin
          idx_d      = '0;
          csum_d     = '0;
          out_data_d = HEADER;
        end
      end
      S_SEND: begin
        if (out_valid_q && stream.out_ready) begin
          csum_d = csum_q ^ out_data_q;
          if (idx_q == IDX_W'(NBYTES - 1)) begin
            out_data_d = '0;
            state_d    = S_DONE;
          end else begin
            idx_d      = nxt_idx;
            out_data_d = (nxt_idx == IDX_W'(NBYTES - 1)) ? csum_d : nxt_byte;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    out_valid_d = (state_d == S_SEND);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      finish_d_q  <= 1'b0;
      cnt_q       <= '0;
      x2_q        <= '0;
      loop_q      <= '0;
      div_q       <= '0;
      q_q         <= '0;
      rem_q       <= '0;
      flags_q     <= '0;
      idx_q       <= '0;
      csum_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      finish_d_q  <= finish;
      cnt_q       <= cnt_d;
      x2_q        <= x2_d;
      loop_q      <= loop_d;
      div_q       <= div_d;
      q_q         <= q_d;
      rem_q       <= rem_d;
      flags_q     <= flags_d;
      idx_q       <= idx_d;
      csum_q      <= csum_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign stream.out_data  = out_data_q;
  assign stream.out_valid = out_valid_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: tb/tb_piho_result_sink.sv
module tb_piho_result_sink;
  localparam int unsigned SETTLE   = 4;
  localparam logic [7:0]  HDR      = 8'hA5;
  localparam int unsigned LAT_DIV  = SETTLE + 66;  // negedges after finish raise until out_valid seen
  localparam int unsigned LAT_ZERO = SETTLE + 2;
  localparam int unsigned NVEC     = 10;

  typedef struct {
    logic [63:0] x2;
    logic [31:0] lt;
    logic [31:0] conf;
    logic [31:0] dump;
    bit          stall;
    bit          vary;
    logic [63:0] exp_x2;
    logic [63:0] exp_q;
    logic [7:0]  exp_flags;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        finish;
  logic [63:0] x2sumall;
  logic [31:0] looptimes;
  logic [31:0] MCNconf;
  logic [31:0] MCNdump;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  vec_t vecs[NVEC];

  piho_result_sink_if sif ();

  piho_result_sink #(.SETTLE(SETTLE), .HEADER(HDR)) dut (
    .clk       (clk),
    .rst       (rst),
    .finish    (finish),
    .x2sumall  (x2sumall),
    .looptimes (looptimes),
    .MCNconf   (MCNconf),
    .MCNdump   (MCNdump),
    .stream    (sif),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drop finish for one cycle, apply operands, raise finish and wait for out_valid.
  task automatic start_frame(input vec_t v, output int cyc);
    finish = 1'b0;
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);
    x2sumall       = v.x2;
    looptimes      = v.lt;
    MCNconf        = v.conf;
    MCNdump        = v.dump;
    finish         = 1'b1;
    sif.out_ready  = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (v.vary && cyc <= 6) x2sumall = v.x2 + 64'(cyc);
    end while (!sif.out_valid && cyc < 200);
  endtask

  task automatic run_vec(input vec_t v, input int n);
    logic [7:0] exp [23];
    logic [7:0] held;
    int cyc;
    int nb;
    int stall;
    int guard;
    exp[0] = HDR;
    exp[1] = v.exp_flags;
    for (int i = 0; i < 8; i++) exp[2 + i]  = v.exp_x2[8*i +: 8];
    for (int i = 0; i < 8; i++) exp[10 + i] = v.exp_q[8*i +: 8];
    for (int i = 0; i < 4; i++) exp[18 + i] = v.lt[8*i +: 8];
    exp[22] = '0;
    for (int i = 0; i < 22; i++) exp[22] = exp[22] ^ exp[i];

    start_frame(v, cyc);
    check($sformatf("v%0d_latency", n), 64'(cyc),
          64'(v.exp_flags[0] ? LAT_ZERO : LAT_DIV));
    if (!sif.out_valid) return;

    nb = 0; stall = 0; guard = 0;
    while (nb < 23 && guard < 400) begin
      if (stall > 0) begin
        stall--;
        sif.out_ready = 1'b0;
        held = sif.out_data;
        @(negedge clk);
        guard++;
        check($sformatf("v%0d_stall_hold", n), 64'(sif.out_data), 64'(held));
        check($sformatf("v%0d_stall_valid", n), 64'(sif.out_valid), 64'd1);
      end else begin
        check($sformatf("v%0d_valid_b%0d", n, nb), 64'(sif.out_valid), 64'd1);
        sif.out_ready = 1'b1;
        check($sformatf("v%0d_byte%0d", n, nb), 64'(sif.out_data), 64'(exp[nb]));
        nb++;
        if (v.stall) stall = int'($urandom_range(0, 5));
        @(negedge clk);
        guard++;
      end
    end
    check($sformatf("v%0d_bytes_done", n), 64'(nb), 64'd23);
    check($sformatf("v%0d_done_pulse", n), 64'(done), 64'd1);
    check($sformatf("v%0d_busy_in_done", n), 64'(busy), 64'd1);
    check($sformatf("v%0d_valid_off", n), 64'(sif.out_valid), 64'd0);
    sif.out_ready = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d_done_low", n), 64'(done), 64'd0);
    check($sformatf("v%0d_busy_low", n), 64'(busy), 64'd0);
  endtask

  initial begin
    int cyc;
    int vcount;

    //          x2                         lt            conf   dump   stall vary exp_x2                      exp_q                       flags
    vecs[0] = '{64'd1000,                  32'd100,      32'd100, 32'd20, 1'b0, 1'b0, 64'd1000,                  64'd12,                     8'h00};
    vecs[1] = '{64'd77,                    32'd5,        32'd50,  32'd50, 1'b0, 1'b0, 64'd77,                    64'hFFFF_FFFF_FFFF_FFFF,    8'h01};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF,   32'hDEAD_BEEF,32'd1,   32'd0,  1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF,   64'hFFFF_FFFF_FFFF_FFFF,    8'h00};
    vecs[3] = '{64'h0123_4567_89AB_CDEF,   32'h1234_5678,32'd16,  32'd0,  1'b1, 1'b0, 64'h0123_4567_89AB_CDEF,   64'h0012_3456_789A_BCDE,    8'h00};
    vecs[4] = '{64'd7,                     32'd9,        32'd10,  32'd3,  1'b0, 1'b0, 64'd7,                     64'd1,                      8'h00};
    vecs[5] = '{64'd6,                     32'd10,       32'd10,  32'd3,  1'b1, 1'b0, 64'd6,                     64'd0,                      8'h00};
    vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFF,   32'd42,       32'd0,   32'd1,  1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF,   64'h0000_0001_0000_0001,    8'h00};
    vecs[7] = '{64'h0000_00E8_D4A5_1000,   32'd3,        32'd3,   32'd0,  1'b1, 1'b0, 64'h0000_00E8_D4A5_1000,   64'h0000_004D_9C37_0555,    8'h00};
    vecs[8] = '{64'h0000_0000_0000_1000,   32'd8,        32'd1,   32'd0,  1'b0, 1'b1, 64'h0000_0000_0000_1004,   64'h0000_0000_0000_1004,    8'h00};
    vecs[9] = '{64'h55,                    32'd1,        32'd7,   32'd7,  1'b1, 1'b0, 64'h55,                    64'hFFFF_FFFF_FFFF_FFFF,    8'h01};

    rst = 1'b1; finish = 1'b0; x2sumall = '0; looptimes = '0;
    MCNconf = '0; MCNdump = '0; sif.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_data", 64'(sif.out_data), 64'd0);
    check("rst_out_valid", 64'(sif.out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Reset while byte 10 is presented: frame abandoned, not resumed.
    start_frame(vecs[0], cyc);
    check("rs_latency", 64'(cyc), 64'(LAT_DIV));
    for (int i = 0; i < 10; i++) begin
      sif.out_ready = 1'b1;
      @(negedge clk);
    end
    check("rs_byte10", 64'(sif.out_data), 64'h0C);
    rst = 1'b1; finish = 1'b0; sif.out_ready = 1'b0;
    @(negedge clk);
    check("rs_out_data", 64'(sif.out_data), 64'd0);
    check("rs_out_valid", 64'(sif.out_valid), 64'd0);
    check("rs_busy", 64'(busy), 64'd0);
    check("rs_done", 64'(done), 64'd0);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    check("rs_no_resume_valid", 64'(sif.out_valid), 64'd0);
    check("rs_no_resume_busy", 64'(busy), 64'd0);

    // Fresh frame after the abandoned one.
    run_vec(vecs[0], 10);

    // finish held high: no second frame.
    vcount = 0;
    sif.out_ready = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (sif.out_valid || busy) vcount++;
    end
    sif.out_ready = 1'b0;
    check("hold_high_no_frame", 64'(vcount), 64'd0);

    // finish low for one cycle then high again: second frame, including capture timing.
    run_vec(vecs[8], 8);
    run_vec(vecs[9], 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/piho_result_sink.md
# piho_result_sink

Downstream consumer of the 8-unit path-integral harmonic-oscillator array. On the array's `finish` rising edge it waits out the x2sum adder-tree pipeline and captures the total `x2sumall` plus `looptimes`. It then computes the per-configuration mean `x2sumall / (MCNconf - MCNdump)` with a serial restoring divider. The results go out as a checksummed byte frame over a valid/ready stream, toward the UART/host bridge.

## Interface
Parameters:
- `SETTLE`, default 4: cycles between the first sample of `finish` high and the capture of `x2sumall`. Equals the adder-tree register depth.
- `HEADER`, default 8'hA5: first byte of every frame.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `finish`  in  1  level from the array; high once the run completes.
- `x2sumall`  in  64  pipelined total of the eight unit sums.
- `looptimes`  in  32  loop counter from the array.
- `MCNconf`  in  32  total configurations (same value fed to the array).
- `MCNdump`  in  32  warm-up configurations discarded.
- `out_data`  out  8  frame byte.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts the byte when `out_valid` is also high.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last byte is accepted.

## Operation
- Edge detect: `finish_d` is `finish` registered. A start event is `finish & ~finish_d`, sampled in IDLE only. Start events in any other state are ignored.
- States:
  - IDLE: on a start event, go to SETTLE and load the settle counter with `SETTLE-1`.
  - SETTLE: decrement the counter. When it is 0, capture `x2sumall`, `looptimes` and `div = MCNconf - MCNdump` (32-bit, wraps modulo 2^32), then go to DIVIDE.
  - DIVIDE: if `div == 0`, set flag bit0, set the quotient to 64'hFFFF_FFFF_FFFF_FFFF and go straight to SEND. Otherwise run a restoring division: 64 iterations, one quotient bit per cycle MSB-first, with a 33-bit partial remainder. Then go to SEND.
  - SEND: emit 23 bytes, index 0..22. Advance only on `out_valid & out_ready`. After byte 22 is accepted, go to DONE.
  - DONE: assert `done` for one cycle, then go to IDLE.
- Frame, multi-byte fields LSB-first:
  - byte 0: `HEADER`.
  - byte 1: flags. bit0 = divide-by-zero, bits 7:1 = 0.
  - bytes 2..9: captured `x2sumall`.
  - bytes 10..17: quotient (unsigned floor).
  - bytes 18..21: captured `looptimes`.
  - byte 22: XOR of bytes 0..21.
- The running checksum is accumulated as bytes are accepted, not precomputed.
- All arithmetic is unsigned. The remainder is discarded.
- Inputs other than `finish` and `out_ready` are ignored outside the capture edge.

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `busy`=0, `done`=0. Internally: state IDLE, `finish_d`=0, flags=0, byte index=0, checksum=0.
- Reset has priority in every state, including mid-DIVIDE and mid-SEND. A partial frame is abandoned and never resumed.
- If `finish` is already high when reset is released, the next edge detects a start event, because `finish_d` resets to 0.
- Let edge k be the first edge at which `finish`=1 and `finish_d`=0.
  - Capture of `x2sumall` occurs at edge k+SETTLE.
  - With `div` ≠ 0, the quotient is final at edge k+SETTLE+64. `out_valid` rises after edge k+SETTLE+65, presenting byte 0.
  - With `div` = 0, `out_valid` rises after edge k+SETTLE+1.
- Handshake:
  - `out_data` is held stable while `out_valid & ~out_ready`.
  - `out_valid` does not depend combinationally on `out_ready`.
  - Back-to-back acceptance gives one byte per cycle. `out_valid` stays high through all 23 bytes.
- `done` pulses on the cycle after byte 22 is accepted. `busy` falls together with the `done` pulse.
- A new frame requires `finish` to fall and rise again. Holding `finish` high produces exactly one frame.

## Test plan
- `x2sumall`=1000, `MCNconf`=100, `MCNdump`=20, `looptimes`=100, `out_ready`=1 throughout. Expected frame: A5, 00, E8 03 00 00 00 00 00 00, 0C 00 00 00 00 00 00 00, 64 00 00 00, then the checksum (XOR of bytes 0..21). `out_valid` first high 4+65 cycles after edge k. `done` pulses once.
- `MCNconf`=`MCNdump`=50 → flags=01, quotient bytes all FF, `out_valid` high after edge k+5.
- Random `out_ready` stalls of 0–5 cycles → `out_data` is unchanged during every stall, the 23 bytes arrive in order, and the checksum is correct.
- `x2sumall` changes on every cycle from k to k+6 → the captured value is the one present at edge k+4 (`SETTLE`=4).
- `rst` asserted at byte 10 of SEND → all outputs return to reset values on the next edge. A fresh `finish` rise then produces a complete, correct frame.
- `finish` held high for 500 cycles → exactly one frame. `finish` low for 1 cycle then high again after DONE → a second frame.
